// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute-stage ALU.
//  Base integer ops finish in one cycle; RV32M multiply/divide iterate one bit
//  per cycle on a shared hi:lo register pair, then a fix-up cycle applies signs.
//  Optional macro: ALU_SEQ_FAST_MUL_EN -- mul/mulh/mulhsu/mulhu use a single
//  array multiplier and complete in one cycle; div/rem remain iterative.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             less,
  output logic             zero,
  output logic             busy
);

  localparam int                 SH_W     = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2     = (2*WIDTH)'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH-1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Context captured when an M-ext op is accepted.
  typedef struct packed {
    logic [2:0]       f3;     // funct3
    logic             neg_q;  // negate product / quotient in FIX
    logic             neg_r;  // negate remainder in FIX
    logic             dz;     // divisor was zero
    logic [WIDTH-1:0] a_raw;  // original dividend for rem-by-zero
    logic [WIDTH-1:0] mc;     // multiplicand (mul) or divisor magnitude (div)
  } mctx_t;

  state_t           state, state_nxt;
  mctx_t            ctx;
  logic [WIDTH-1:0] hi, lo;
  logic [CNT_W-1:0] cnt;

  // ---------------- single-cycle base datapath ----------------
  logic             sub_en, add_cout, add_ovf, base_less;
  logic [WIDTH-1:0] b_op, add_res, shift_res, base_res;
  logic [WIDTH:0]   add_full;
  logic [SH_W-1:0]  shamt;

  // Shared adder/subtractor, shifter and logic unit keyed by ALUctr.
  always_comb begin
    sub_en    = op[3] | op[1];
    b_op      = sub_en ? ~datab : datab;
    add_full  = {1'b0, dataa} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_en};
    add_res   = add_full[WIDTH-1:0];
    add_cout  = add_full[WIDTH];
    add_ovf   = (dataa[WIDTH-1] == b_op[WIDTH-1]) & (add_res[WIDTH-1] != dataa[WIDTH-1]);
    // unsigned compare: borrow out of a-b; signed: sign corrected by overflow
    base_less = op[0] ? ~add_cout : (add_res[WIDTH-1] ^ add_ovf);
    shamt     = datab[SH_W-1:0];
    if (!op[2])     shift_res = dataa << shamt;
    else if (op[3]) shift_res = $signed(dataa) >>> shamt;
    else            shift_res = dataa >> shamt;
    casez (op[3:0])
      4'b?000: base_res = add_res;
      4'b??01: base_res = shift_res;
      4'b001?: base_res = {{(WIDTH-1){1'b0}}, base_less};
      4'b0100: base_res = dataa ^ datab;
      4'b0110: base_res = dataa | datab;
      4'b0111: base_res = dataa & datab;
      4'b1111: base_res = datab;
      default: base_res = add_res;
    endcase
  end

  // ---------------- M-ext operand preparation ----------------
  logic [2:0]       f3;
  logic             a_sgn, b_sgn, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Signedness per funct3 and operand magnitudes for the unsigned core.
  always_comb begin
    f3    = op[2:0];
    a_sgn = (f3 == 3'b001) | (f3 == 3'b010) | (f3 == 3'b100) | (f3 == 3'b110);
    b_sgn = (f3 == 3'b001) | (f3 == 3'b100) | (f3 == 3'b110);
    sa    = a_sgn & dataa[WIDTH-1];
    sb    = b_sgn & datab[WIDTH-1];
    mag_a = sa ? (~dataa + ONE) : dataa;
    mag_b = sb ? (~datab + ONE) : datab;
  end

  // ---------------- one-cycle result selection ----------------
  logic             one_shot, one_less, one_zero;
  logic [WIDTH-1:0] one_res;

`ifdef ALU_SEQ_FAST_MUL_EN
  logic [2*WIDTH-1:0] fa, fb, fprod;
  logic [WIDTH-1:0]   fast_res;

  // Sign-extended full product; low or high half picked by funct3.
  always_comb begin
    fa       = {{WIDTH{sa}}, dataa};
    fb       = {{WIDTH{sb}}, datab};
    fprod    = fa * fb;
    fast_res = (f3 == 3'b000) ? fprod[WIDTH-1:0] : fprod[2*WIDTH-1:WIDTH];
    one_shot = ~op[4] | ~op[2];
    one_res  = op[4] ? fast_res : base_res;
    one_less = op[4] ? 1'b0 : base_less;
    one_zero = op[4] ? (fast_res == '0) : (add_res == '0);
  end
`else
  // Only base ops complete in the accept cycle.
  always_comb begin
    one_shot = ~op[4];
    one_res  = base_res;
    one_less = base_less;
    one_zero = (add_res == '0);
  end
`endif

  // ---------------- iterative step and fix-up ----------------
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_diff, quot, remd, fix_res;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_s;

  // One shift-add / restoring-divide step, plus sign fix and result select.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, ctx.mc} : {(WIDTH+1){1'b0}});
    div_sh   = {hi, lo[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, ctx.mc});
    // when div_ge holds the difference is below the divisor, so WIDTH bits suffice
    div_diff = div_sh[WIDTH-1:0] - ctx.mc;
    prod     = {hi, lo};
    prod_s   = ctx.neg_q ? (~prod + ONE2) : prod;
    quot     = ctx.neg_q ? (~lo + ONE) : lo;
    remd     = ctx.neg_r ? (~hi + ONE) : hi;
    case (ctx.f3)
      3'b000:                fix_res = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:        fix_res = ctx.dz ? {WIDTH{1'b1}} : quot;
      default:               fix_res = ctx.dz ? ctx.a_raw : remd;
    endcase
  end

  // ---------------- control ----------------
  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: base ops skip straight to DONE, M-ext runs WIDTH CALC cycles then FIX.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = one_shot ? DONE : CALC;
      CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: capture on accept, iterate in CALC, publish in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      less   <= 1'b0;
      zero   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      ctx    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (one_shot) begin
            result <= one_res;
            less   <= one_less;
            zero   <= one_zero;
          end else begin
            ctx.f3    <= f3;
            ctx.neg_q <= sa ^ sb;
            ctx.neg_r <= sa;
            ctx.dz    <= (datab == '0);
            ctx.a_raw <= dataa;
            ctx.mc    <= op[2] ? mag_b : mag_a;
            hi        <= '0;
            lo        <= op[2] ? mag_a : mag_b;
            cnt       <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_ONE;
          if (ctx.f3[2]) begin
            hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], div_ge};
          end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          result <= fix_res;
          less   <= 1'b0;
          zero   <= (fix_res == '0);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
